// File: rtl/score_keeper_bcd.sv
// score_keeper_bcd: a multi-digit BCD game score with a session high score.
//
// Award requests arrive over a valid/ready handshake. An award of N points is
// applied one point per clock while add_ready_o is low. The block also tracks
// the session high score and drives active-low seven-segment patterns for
// every digit.
//
// Ports:
//   clk_i        system clock; all state changes on the rising edge
//   reset_i      synchronous, active-high; clears score, high score and FSM
//   enable_i     game active; low clears the current game and keeps the high score
//   add_valid_i  award request valid
//   add_pts_i    points to award, unsigned
//   add_ready_o  the block can accept an award this cycle
//   show_high_i  display select: 0 = score, 1 = high score
//   score_bcd_o  current score, digit 0 in [3:0]
//   high_bcd_o   session high score
//   new_high_o   sticky: the current game has beaten the previous high score
//   saturated_o  sticky: the score reached all 9s and points were dropped
//   hex_seg_o    active-low segments; digit i in [7i+6:7i]; bit0 = a ... bit6 = g
module score_keeper_bcd #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PTS_W    = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                add_valid_i,
  input  logic [PTS_W-1:0]    add_pts_i,
  output logic                add_ready_o,
  input  logic                show_high_i,
  output logic [4*DIGITS-1:0] score_bcd_o,
  output logic [4*DIGITS-1:0] high_bcd_o,
  output logic                new_high_o,
  output logic                saturated_o,
  output logic [7*DIGITS-1:0] hex_seg_o
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   score_q, score_d;
  logic [4*DIGITS-1:0]   high_q, high_d;
  logic [PTS_W-1:0]      remaining_q, remaining_d;
  logic                  new_high_q, new_high_d;
  logic                  saturated_q, saturated_d;

  logic [4*DIGITS-1:0]   score_inc;
  logic                  all_nines;
  logic                  inc_carry;
  logic [3:0]            inc_digit;
  logic                  award_start;

  // Active-low gfedcba pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // BCD +1 with a combinational ripple carry; also flags the all-9s score.
  always_comb begin
    score_inc = score_q;
    all_nines = 1'b1;
    inc_carry = 1'b1;
    inc_digit = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      inc_digit = score_q[4*i +: 4];
      if (inc_digit != 4'd9) all_nines = 1'b0;
      if (inc_carry) begin
        if (inc_digit == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = inc_digit + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  // A zero-point award completes the handshake but never leaves idle.
  assign award_start = add_valid_i && (add_pts_i != '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (award_start) state_d = StCount;
      StCount: if (all_nines || remaining_q == PTS_W'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
  end

  always_comb begin
    add_ready_o = enable_i && (state_q == StIdle);
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    score_d     = score_q;
    high_d      = high_q;
    remaining_d = remaining_q;
    new_high_d  = new_high_q;
    saturated_d = saturated_q;
    if (!enable_i) begin
      score_d     = '0;
      remaining_d = '0;
      new_high_d  = 1'b0;
      saturated_d = 1'b0;
    end else begin
      // Unsigned compare of packed nibbles orders BCD values correctly.
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
      if (state_q == StIdle) begin
        if (award_start) remaining_d = add_pts_i;
      end else if (all_nines) begin
        // Score pinned at the maximum: drop whatever is left of the award.
        saturated_d = 1'b1;
        remaining_d = '0;
      end else begin
        score_d     = score_inc;
        remaining_d = remaining_q - PTS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q     <= '0;
      high_q      <= '0;
      remaining_q <= '0;
      new_high_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      remaining_q <= remaining_d;
      new_high_q  <= new_high_d;
      saturated_q <= saturated_d;
    end
  end

  assign score_bcd_o = score_q;
  assign high_bcd_o  = high_q;
  assign new_high_o  = new_high_q;
  assign saturated_o = saturated_q;

  // ------------------------------------------------------------ display
  logic [4*DIGITS-1:0] disp_val;
  logic                disp_seen_nz;
  logic [3:0]          disp_digit;

  assign disp_val = show_high_i ? high_q : score_q;

  // Walk from the most significant digit down; a digit is a leading zero
  // until some digit at or above it is non-zero. Digit 0 always shows.
  always_comb begin
    hex_seg_o    = '1;
    disp_seen_nz = 1'b0;
    disp_digit   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      disp_digit = disp_val[4*i +: 4];
      if (disp_digit != 4'd0) disp_seen_nz = 1'b1;
      if (BLANK_LZ && (i != 0) && !disp_seen_nz) begin
        hex_seg_o[7*i +: 7] = 7'b1111111;
      end else begin
        hex_seg_o[7*i +: 7] = seg7(disp_digit);
      end
    end
  end

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Directed bench for score_keeper_bcd with DIGITS=4, PTS_W=4, BLANK_LZ=1.
module tb_score_keeper_bcd;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        add_valid;
  logic [3:0]  add_pts;
  logic        add_ready;
  logic        show_high;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        new_high;
  logic        saturated;
  logic [27:0] hex_seg;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;

  score_keeper_bcd #(
    .DIGITS  (4),
    .PTS_W   (4),
    .BLANK_LZ(1'b1)
  ) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .add_valid_i(add_valid),
    .add_pts_i  (add_pts),
    .add_ready_o(add_ready),
    .show_high_i(show_high),
    .score_bcd_o(score_bcd),
    .high_bcd_o (high_bcd),
    .new_high_o (new_high),
    .saturated_o(saturated),
    .hex_seg_o  (hex_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an award, then return how many cycles add_ready stays low.
  task automatic award(input logic [3:0] pts, output int cycles);
    int guard;
    guard     = 0;
    add_valid = 1'b1;
    add_pts   = pts;
    while (!add_ready && guard < 100) begin
      step();
      guard++;
    end
    step();
    add_valid = 1'b0;
    cycles    = 0;
    while (!add_ready && cycles < 100) begin
      step();
      cycles++;
    end
    if (!add_ready) check("award_timeout", 32'(add_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    add_valid = 1'b0;
    add_pts   = '0;
    show_high = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_high", 32'(high_bcd), 32'h0);
    check("rst_ready", 32'(add_ready), 32'd1);
    check("rst_flags", {30'd0, new_high, saturated}, 32'd0);
    check("rst_hex", 32'(hex_seg), 32'({BL, BL, BL, S0}));

    // Award 5: score climbs one per edge, ready low for exactly 5 cycles
    add_valid = 1'b1;
    add_pts   = 4'd5;
    step();
    add_valid = 1'b0;
    check("a5_accept_score", 32'(score_bcd), 32'h0);
    for (int n = 1; n <= 5; n++) begin
      check("a5_ready_low", 32'(add_ready), 32'd0);
      step();
      check("a5_score", 32'(score_bcd), 32'(n));
    end
    check("a5_ready_back", 32'(add_ready), 32'd1);
    check("a5_high_lag", 32'(high_bcd), 32'h4);
    step();
    check("a5_high", 32'(high_bcd), 32'h5);
    check("a5_new_high", 32'(new_high), 32'd1);

    // Zero-point award is a no-op that keeps ready high
    add_valid = 1'b1;
    add_pts   = 4'd0;
    step();
    add_valid = 1'b0;
    check("zero_ready", 32'(add_ready), 32'd1);
    check("zero_score", 32'(score_bcd), 32'h5);

    // Game ends mid-award: 4 points, abort after two increments
    add_valid = 1'b1;
    add_pts   = 4'd4;
    step();
    add_valid = 1'b0;
    step();
    step();
    check("abort_pre", 32'(score_bcd), 32'h7);
    enable = 1'b0;
    step();
    check("off_score", 32'(score_bcd), 32'h0);
    check("off_ready", 32'(add_ready), 32'd0);
    check("off_flags", {30'd0, new_high, saturated}, 32'd0);
    check("off_high", 32'(high_bcd), 32'h6);
    add_valid = 1'b1;
    add_pts   = 4'd3;
    step();
    add_valid = 1'b0;
    check("off_ignore", 32'(score_bcd), 32'h0);
    show_high = 1'b1;
    #1;
    check("hex_high", 32'(hex_seg), 32'({BL, BL, BL, S6}));
    show_high = 1'b0;
    #1;
    check("hex_score0", 32'(hex_seg), 32'({BL, BL, BL, S0}));

    // Second game stays below the high score
    enable = 1'b1;
    step();
    award(4'd3, cyc);
    check("g2_cycles", 32'(cyc), 32'd3);
    step();
    check("g2_score", 32'(score_bcd), 32'h3);
    check("g2_high", 32'(high_bcd), 32'h6);
    check("g2_new_high", 32'(new_high), 32'd0);

    // Preload 98, then award 3 across the two-digit carry
    for (int i = 0; i < 6; i++) award(4'd15, cyc);
    award(4'd5, cyc);
    check("pre98", 32'(score_bcd), 32'h98);
    add_valid = 1'b1;
    add_pts   = 4'd3;
    step();
    add_valid = 1'b0;
    step();
    check("c_99", 32'(score_bcd), 32'h99);
    step();
    check("c_100", 32'(score_bcd), 32'h100);
    check("c_hex100", 32'(hex_seg), 32'({BL, S1, S0, S0}));
    step();
    check("c_101", 32'(score_bcd), 32'h101);
    check("c_hex101", 32'(hex_seg), 32'({BL, S1, S0, S1}));
    check("c_ready", 32'(add_ready), 32'd1);
    check("c_new_high", 32'(new_high), 32'd1);

    // Climb to 9997 (9896 more points), then award 7 into saturation
    for (int i = 0; i < 659; i++) award(4'd15, cyc);
    award(4'd11, cyc);
    check("pre9997", 32'(score_bcd), 32'h9997);
    add_valid = 1'b1;
    add_pts   = 4'd7;
    step();
    add_valid = 1'b0;
    step();
    check("s_9998", 32'(score_bcd), 32'h9998);
    step();
    check("s_9999", 32'(score_bcd), 32'h9999);
    check("s_not_yet", 32'({add_ready, saturated}), 32'd0);
    step();
    check("s_sat", 32'(saturated), 32'd1);
    check("s_ready", 32'(add_ready), 32'd1);
    check("s_hold", 32'(score_bcd), 32'h9999);
    award(4'd4, cyc);
    check("s_noop_cycles", 32'(cyc), 32'd1);
    check("s_noop_score", 32'(score_bcd), 32'h9999);
    check("s_hex", 32'(hex_seg), 32'({S9, S9, S9, S9}));
    check("s_high", 32'(high_bcd), 32'h9999);

    // Reset clears the high score too
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r_high", 32'(high_bcd), 32'h0);
    check("r_score", 32'(score_bcd), 32'h0);
    check("r_sat", 32'(saturated), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
